// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared state encoding and memory geometry for the data memory master
package mem_pkg;
    localparam int MEM_DEPTH = 4096;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        CRD  = 3'd3,
        CWR  = 3'd4,
        CFIN = 3'd5
    } state_t;
endpackage

// File: rtl/mem_copy_ctr.sv
// rtl/mem_copy_ctr.sv - block-copy index counter, last-word compare and wrapping address adders
module mem_copy_ctr #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              inc_i,
    input  logic [ADDR_W-1:0] src_i,
    input  logic [ADDR_W-1:0] dst_i,
    input  logic [ADDR_W:0]   len_i,
    output logic [ADDR_W-1:0] src_addr_o,
    output logic [ADDR_W-1:0] src_next_o,
    output logic [ADDR_W-1:0] dst_addr_o,
    output logic              last_o
);
    logic [ADDR_W-1:0] src_q, dst_q;
    logic [ADDR_W:0]   len_q, idx_q, idx_d;

    always_comb begin
        idx_d = idx_q;
        if (load_i)
            idx_d = '0;
        else if (inc_i)
            idx_d = idx_q + (ADDR_W+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q <= '0;
            dst_q <= '0;
            len_q <= '0;
            idx_q <= '0;
        end else begin
            if (load_i) begin
                src_q <= src_i;
                dst_q <= dst_i;
                len_q <= len_i;
            end
            idx_q <= idx_d;
        end
    end

    // Truncation to ADDR_W bits gives the modulo-4096 wrap for free.
    assign src_addr_o = src_q + idx_q[ADDR_W-1:0];
    assign src_next_o = src_q + idx_q[ADDR_W-1:0] + ADDR_W'(1);
    assign dst_addr_o = dst_q + idx_q[ADDR_W-1:0];
    assign last_o     = ((idx_q + (ADDR_W+1)'(1)) == len_q);
endmodule

// File: rtl/data_mem_master.sv
// rtl/data_mem_master.sv - data memory initiator serving CPU load/store and a block-copy engine
module data_mem_master
    import mem_pkg::*;
#(
    parameter int bit_size = 15,
    parameter int ADDR_W   = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                reqValid,
    input  logic                reqWrite,
    input  logic [ADDR_W-1:0]   reqAddr,
    input  logic [bit_size:0]   reqData,
    output logic                reqReady,
    output logic                rspValid,
    output logic [bit_size:0]   rspData,
    input  logic                copyStart,
    input  logic [ADDR_W-1:0]   copySrc,
    input  logic [ADDR_W-1:0]   copyDst,
    input  logic [ADDR_W:0]     copyLen,
    output logic                busy,
    output logic                copyDone,
    output logic                dataMemRead,
    output logic                dataMemWrite,
    output logic [ADDR_W-1:0]   address,
    output logic [bit_size:0]   value,
    input  logic [bit_size:0]   memOut
);
    state_t            state_q;
    logic              ready_q, rsp_valid_q, busy_q, done_q, rd_q, wr_q;
    logic [bit_size:0] rsp_data_q, value_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] src_addr, src_next, dst_addr;
    logic              last;
    logic              copy_load;

    assign copy_load = (state_q == IDLE) && ready_q && copyStart;

    mem_copy_ctr #(.ADDR_W(ADDR_W)) u_ctr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (copy_load),
        .inc_i      (state_q == CWR),
        .src_i      (copySrc),
        .dst_i      (copyDst),
        .len_i      (copyLen),
        .src_addr_o (src_addr),
        .src_next_o (src_next),
        .dst_addr_o (dst_addr),
        .last_o     (last)
    );

    // Strobes and address are computed one cycle ahead so they leave straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            value_q     <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            done_q      <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!ready_q) begin
                        ready_q <= 1'b1;
                    end else if (copyStart && (copyLen == '0)) begin
                        ready_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= CFIN;
                    end else if (copyStart) begin
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        rd_q    <= 1'b1;
                        addr_q  <= copySrc;
                        state_q <= CRD;
                    end else if (reqValid) begin
                        ready_q <= 1'b0;
                        addr_q  <= reqAddr;
                        value_q <= reqData;
                        if (reqWrite) begin
                            wr_q    <= 1'b1;
                            state_q <= WR;
                        end else begin
                            rd_q    <= 1'b1;
                            state_q <= RD;
                        end
                    end
                end
                RD: begin
                    rsp_data_q  <= memOut;
                    rsp_valid_q <= 1'b1;
                    ready_q     <= 1'b1;
                    state_q     <= IDLE;
                end
                WR: begin
                    rsp_valid_q <= 1'b1;
                    ready_q     <= 1'b1;
                    state_q     <= IDLE;
                end
                CRD: begin
                    value_q <= memOut;
                    addr_q  <= dst_addr;
                    wr_q    <= 1'b1;
                    state_q <= CWR;
                end
                CWR: begin
                    if (last) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= CFIN;
                    end else begin
                        rd_q    <= 1'b1;
                        addr_q  <= src_next;
                        state_q <= CRD;
                    end
                end
                CFIN: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign reqReady     = ready_q;
    assign rspValid     = rsp_valid_q;
    assign rspData      = rsp_data_q;
    assign busy         = busy_q;
    assign copyDone     = done_q;
    assign dataMemRead  = rd_q;
    assign dataMemWrite = wr_q;
    assign address      = addr_q;
    assign value        = value_q;
endmodule

// File: tb/tb_data_mem_master.sv
// tb/tb_data_mem_master.sv - randomized self-checking bench for data_mem_master against a memory model
module tb_data_mem_master;
    import mem_pkg::*;

    localparam int AW = 12;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          reqValid = 1'b0, reqWrite = 1'b0;
    logic [AW-1:0] reqAddr = '0;
    logic [DW-1:0] reqData = '0;
    logic          reqReady, rspValid;
    logic [DW-1:0] rspData;
    logic          copyStart = 1'b0;
    logic [AW-1:0] copySrc = '0, copyDst = '0;
    logic [AW:0]   copyLen = '0;
    logic          busy, copyDone, dataMemRead, dataMemWrite;
    logic [AW-1:0] address;
    logic [DW-1:0] value, memOut;

    logic [DW-1:0] mem     [MEM_DEPTH];
    logic [DW-1:0] ref_mem [MEM_DEPTH];
    logic [AW-1:0] rd_log[$];
    int            both_cnt = 0;
    int            n_checks = 0, n_pass = 0;

    data_mem_master #(.bit_size(DW-1), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .reqValid(reqValid), .reqWrite(reqWrite), .reqAddr(reqAddr), .reqData(reqData),
        .reqReady(reqReady), .rspValid(rspValid), .rspData(rspData),
        .copyStart(copyStart), .copySrc(copySrc), .copyDst(copyDst), .copyLen(copyLen),
        .busy(busy), .copyDone(copyDone),
        .dataMemRead(dataMemRead), .dataMemWrite(dataMemWrite),
        .address(address), .value(value), .memOut(memOut)
    );

    always #5 clk = ~clk;

    assign memOut = mem[address];

    always @(posedge clk) if (dataMemWrite) mem[address] = value;

    always @(negedge clk) begin
        if (!rst) begin
            if (dataMemRead) rd_log.push_back(address);
            if (dataMemRead && dataMemWrite) both_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic poke(input int a, input logic [DW-1:0] d);
        mem[a]     = d;
        ref_mem[a] = d;
    endtask

    function automatic void model_copy(input int src, input int dst, input int len);
        for (int i = 0; i < len; i++)
            ref_mem[(dst + i) % MEM_DEPTH] = ref_mem[(src + i) % MEM_DEPTH];
    endfunction

    task automatic wait_ready();
        int b = 0;
        while (!reqReady && b < 50) begin
            @(negedge clk);
            b++;
        end
        check("ready_timeout", 32'(reqReady), 32'd1);
    endtask

    task automatic do_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output logic [DW-1:0] rdata, output int lat, output int wr_cyc);
        @(negedge clk);
        reqValid = 1'b1; reqWrite = wr; reqAddr = a; reqData = d;
        wait_ready();
        @(posedge clk);
        #1 reqValid = 1'b0;
        lat = 0; wr_cyc = 0;
        do begin
            @(negedge clk);
            lat++;
            if (dataMemWrite) wr_cyc++;
        end while (!rspValid && lat < 20);
        rdata = rspData;
        if (wr) ref_mem[a] = d;
    endtask

    task automatic do_copy(input int src, input int dst, input int len,
                           output int busy_cyc, output int done_at);
        @(negedge clk);
        copyStart = 1'b1; copySrc = AW'(src); copyDst = AW'(dst); copyLen = (AW+1)'(len);
        wait_ready();
        rd_log.delete();
        @(posedge clk);
        #1 copyStart = 1'b0;
        busy_cyc = 0; done_at = 0;
        for (int n = 1; n <= 2 * len + 20; n++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (copyDone) begin
                done_at = n;
                break;
            end
        end
        model_copy(src, dst, len);
    endtask

    initial begin
        logic [DW-1:0] rd, a_val;
        int lat, wrc, bc, dn, dk, rk, w, errs;
        logic [AW-1:0] ra;

        for (int i = 0; i < MEM_DEPTH; i++) poke(i, DW'($urandom));

        repeat (2) @(negedge clk);
        check("rst_ctl", 32'({reqReady, rspValid, busy, copyDone, dataMemRead, dataMemWrite}), 32'd0);
        check("rst_addr", 32'(address), 32'd0);
        check("rst_value", 32'(value), 32'd0);
        check("rst_rspdata", 32'(rspData), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("ready_after_rst", 32'(reqReady), 32'd1);

        do_req(1'b1, 12'h010, 16'hBEEF, rd, lat, wrc);
        check("store_lat", 32'(lat), 32'd2);
        check("store_wr_cycles", 32'(wrc), 32'd1);
        @(negedge clk);
        check("store_rsp_pulse", 32'(rspValid), 32'd0);
        do_req(1'b0, 12'h010, 16'h0, rd, lat, wrc);
        check("load_lat", 32'(lat), 32'd2);
        check("load_data", 32'(rd), 32'hBEEF);
        do_req(1'b1, 12'h011, 16'h1234, rd, lat, wrc);
        check("rspdata_hold", 32'(rd), 32'hBEEF);

        for (int t = 0; t < 24; t++) begin
            ra = AW'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) begin
                do_req(1'b1, ra, DW'($urandom), rd, lat, wrc);
                check("rnd_store_lat", 32'(lat), 32'd2);
            end else begin
                do_req(1'b0, ra, 16'h0, rd, lat, wrc);
                check("rnd_load", 32'(rd), 32'(ref_mem[ra]));
            end
        end

        for (int i = 0; i < 4; i++) poke(12'h100 + i, DW'(i + 1));
        do_copy(12'h100, 12'h200, 4, bc, dn);
        check("copy4_busy", 32'(bc), 32'd8);
        check("copy4_done_at", 32'(dn), 32'd9);
        @(negedge clk);
        check("copy4_done_pulse", 32'(copyDone), 32'd0);
        for (int i = 0; i < 4; i++) check("copy4_word", 32'(mem[12'h200 + i]), 32'(i + 1));

        do_copy(12'hFFE, 12'h002, 4, bc, dn);
        check("wrap_nreads", 32'(rd_log.size()), 32'd4);
        if (rd_log.size() == 4) begin
            check("wrap_rd0", 32'(rd_log[0]), 32'hFFE);
            check("wrap_rd1", 32'(rd_log[1]), 32'hFFF);
            check("wrap_rd2", 32'(rd_log[2]), 32'h000);
            check("wrap_rd3", 32'(rd_log[3]), 32'h001);
        end
        for (int i = 0; i < 4; i++) check("wrap_word", 32'(mem[2 + i]), 32'(ref_mem[2 + i]));

        do_copy(12'h040, 12'h080, 0, bc, dn);
        check("zero_done_at", 32'(dn), 32'd1);
        check("zero_busy", 32'(bc), 32'd0);
        check("zero_reads", 32'(rd_log.size()), 32'd0);

        @(negedge clk);
        wait_ready();
        copyStart = 1'b1; copySrc = 12'h700; copyDst = 12'h710; copyLen = 13'd2;
        reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 12'h711;
        @(posedge clk);
        #1 copyStart = 1'b0;
        model_copy('h700, 'h710, 2);
        dk = 0; rk = 0; errs = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (rspValid) begin
                if (dk == 0) errs++;
                rk = k;
                break;
            end
            if (copyDone) dk = k;
            if (dk != 0 && k > dk && reqReady) begin
                @(posedge clk);
                #1 reqValid = 1'b0;
            end
        end
        reqValid = 1'b0;
        check("prio_no_early_rsp", 32'(errs), 32'd0);
        check("prio_done_at", 32'(dk), 32'd5);
        check("prio_rsp_after_done", 32'(rk - dk), 32'd3);
        check("prio_load_data", 32'(rspData), 32'(ref_mem[12'h711]));

        a_val = DW'($urandom);
        poke(12'h300, a_val);
        poke(12'h301, DW'($urandom));
        poke(12'h302, DW'($urandom));
        do_copy(12'h300, 12'h301, 3, bc, dn);
        for (int i = 0; i < 4; i++) check("overlap_word", 32'(mem[12'h300 + i]), 32'(a_val));

        for (int t = 0; t < 6; t++) begin
            int s, d, l;
            s = $urandom_range(0, MEM_DEPTH - 1);
            d = $urandom_range(0, MEM_DEPTH - 1);
            l = $urandom_range(1, 8);
            do_copy(s, d, l, bc, dn);
            check("rnd_copy_busy", 32'(bc), 32'(2 * l));
        end

        do_copy(12'h400, 12'h500, 0, bc, dn);
        @(negedge clk);
        wait_ready();
        copyStart = 1'b1; copySrc = 12'h400; copyDst = 12'h500; copyLen = 13'd4;
        @(posedge clk);
        #1 copyStart = 1'b0;
        w = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (dataMemWrite) w++;
            if (w == 3) break;
        end
        check("rstmid_reached_w2", 32'(w), 32'd3);
        rst = 1'b1;
        #1;
        check("rstmid_ctl", 32'({reqReady, rspValid, busy, copyDone, dataMemRead, dataMemWrite}), 32'd0);
        check("rstmid_addr_val", 32'({address, value}), 32'd0);
        model_copy('h400, 'h500, 2);
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            if (copyDone) dn++;
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (copyDone) dn++;
        end
        check("rstmid_no_done", 32'(dn), 32'd0);
        check("rstmid_ready", 32'(reqReady), 32'd1);
        for (int i = 0; i < 4; i++) check("rstmid_word", 32'(mem[12'h500 + i]), 32'(ref_mem[12'h500 + i]));

        errs = 0;
        for (int i = 0; i < MEM_DEPTH; i++) if (mem[i] !== ref_mem[i]) errs++;
        check("mem_all", 32'(errs), 32'd0);
        check("rd_wr_exclusive", 32'(both_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
